skip_mult_counter: RTL and testbench

//  Parametrised up/down counter that can skip nonzero multiples of DIV.

---
 rtl/skip_mult_counter_if.sv | 28 ++
 rtl/skip_mult_counter.sv | 155 +++++++++++++++
 tb/tb_skip_mult_counter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/skip_mult_counter_if.sv
// rtl/skip_mult_counter_if.sv - control and status bundle for skip_mult_counter
interface skip_mult_counter_if #(
  parameter int WIDTH = 4,
  parameter int DIV   = 3
);
  localparam int RW = $clog2(DIV);

  logic             en;
  logic             dir;
  logic             skip_en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic [RW-1:0]    residue;
  logic             wrap;
  logic             busy;

  modport master (
    output en, dir, skip_en, clr, load, load_val,
    input  count, residue, wrap, busy
  );

  modport slave (
    input  en, dir, skip_en, clr, load, load_val,
    output count, residue, wrap, busy
  );
endinterface

// File: rtl/skip_mult_counter.sv
// rtl/skip_mult_counter.sv - up/down counter that can skip nonzero multiples of DIV
module skip_mult_counter #(
  parameter int WIDTH = 4,
  parameter int DIV   = 3,
  parameter int LIMIT = 2**WIDTH-1
) (
  input logic               clk,
  input logic               rst,
  skip_mult_counter_if.slave bus
);
  localparam int RW       = $clog2(DIV);
  // With skipping on, a LIMIT that is itself a multiple can never be reached
  localparam int TOP_SKIP = (LIMIT % DIV == 0) ? LIMIT-1 : LIMIT;

  localparam logic [WIDTH-1:0] TOP_S     = WIDTH'(TOP_SKIP);
  localparam logic [WIDTH-1:0] TOP_P     = WIDTH'(LIMIT);
  localparam logic [RW-1:0]    TOP_S_RES = RW'(TOP_SKIP % DIV);
  localparam logic [RW-1:0]    TOP_P_RES = RW'(LIMIT % DIV);
  localparam logic [WIDTH:0]   LIMIT_X   = (WIDTH+1)'(LIMIT);
  localparam logic [WIDTH-1:0] DIV_W     = WIDTH'(DIV);
  localparam logic [RW:0]      DIV_R     = (RW+1)'(DIV);
  localparam logic [RW-1:0]    DIV_M1    = RW'(DIV-1);

  typedef enum logic {S_RUN, S_CALC} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [RW-1:0]    res_q, res_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] top;
  logic [RW-1:0]    top_res;
  logic [WIDTH-1:0] load_v;
  logic [RW:0]      r_sum;
  logic [RW-1:0]    res_up1;
  logic             up_skip;
  logic [WIDTH:0]   up_n;
  logic [RW-1:0]    res_dn1;
  logic [WIDTH-1:0] dn_n1;
  logic             dn_skip;
  logic             calc_done;
  logic [WIDTH:0]   exit_n;

  assign top       = bus.skip_en ? TOP_S : TOP_P;
  assign top_res   = bus.skip_en ? TOP_S_RES : TOP_P_RES;
  assign load_v    = (bus.load_val > top) ? top : bus.load_val;

  // Residue bookkeeping: step the residue alongside the count instead of dividing
  assign r_sum     = {1'b0, res_q} + (RW+1)'(1);
  assign res_up1   = (r_sum == DIV_R) ? '0 : r_sum[RW-1:0];
  assign up_skip   = bus.skip_en && (r_sum == DIV_R);
  assign up_n      = {1'b0, count_q} + (up_skip ? (WIDTH+1)'(2) : (WIDTH+1)'(1));
  assign res_dn1   = (res_q == '0) ? DIV_M1 : res_q - RW'(1);
  assign dn_n1     = count_q - WIDTH'(1);
  assign dn_skip   = bus.skip_en && (dn_n1 != '0) && (res_dn1 == '0);
  assign calc_done = (work_q < DIV_W);
  assign exit_n    = {1'b0, count_q} + (WIDTH+1)'(1);

  // State register: reset aborts any residue calculation in progress
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_RUN;
    else      state <= state_d;
  end

  // Next state: clear always returns to RUN, load enters CALC, CALC exits when work < DIV
  always_comb begin
    state_d = state;
    if (bus.clr) begin
      state_d = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (bus.load) state_d = S_CALC;
        S_CALC:  if (calc_done) state_d = S_RUN;
        default: state_d = S_RUN;
      endcase
    end
  end

  // Datapath next values: clr > load > en, with en and load ignored during CALC
  always_comb begin
    count_d = count_q;
    work_d  = work_q;
    res_d   = res_q;
    wrap_d  = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      res_d   = '0;
    end else if (state == S_RUN) begin
      if (bus.load) begin
        count_d = load_v;
        work_d  = load_v;
      end else if (bus.en) begin
        if (bus.dir) begin
          if (up_n > LIMIT_X) begin
            count_d = '0;
            res_d   = '0;
            wrap_d  = 1'b1;
          end else begin
            count_d = up_n[WIDTH-1:0];
            res_d   = up_skip ? RW'(1) : res_up1;
          end
        end else begin
          if (count_q == '0) begin
            count_d = top;
            res_d   = top_res;
            wrap_d  = 1'b1;
          end else if (dn_skip) begin
            count_d = count_q - WIDTH'(2);
            res_d   = DIV_M1;
          end else begin
            count_d = dn_n1;
            res_d   = res_dn1;
          end
        end
      end
    end else begin
      if (!calc_done) begin
        work_d = work_q - DIV_W;
      end else begin
        res_d = work_q[RW-1:0];
        // A loaded multiple is stepped past when skipping is on
        if (bus.skip_en && (work_q == '0) && (count_q != '0)) begin
          if (exit_n > LIMIT_X) begin
            count_d = '0;
            res_d   = '0;
          end else begin
            count_d = exit_n[WIDTH-1:0];
            res_d   = RW'(1);
          end
        end
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      work_q  <= '0;
      res_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      work_q  <= work_d;
      res_q   <= res_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.residue = res_q;
  assign bus.wrap    = wrap_q;
  assign bus.busy    = (state == S_CALC);
endmodule

// File: tb/tb_skip_mult_counter.sv
// tb/tb_skip_mult_counter.sv - directed self-checking bench for skip_mult_counter
module tb_skip_mult_counter;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  skip_mult_counter_if #(.WIDTH(4), .DIV(3)) a_if ();
  skip_mult_counter_if #(.WIDTH(4), .DIV(3)) b_if ();

  skip_mult_counter #(.WIDTH(4), .DIV(3), .LIMIT(15)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  skip_mult_counter #(.WIDTH(4), .DIV(3), .LIMIT(12)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  task automatic idle_a();
    a_if.en = 0; a_if.clr = 0; a_if.load = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    a_if.en = 0; a_if.dir = 0; a_if.skip_en = 0; a_if.clr = 0; a_if.load = 0; a_if.load_val = 0;
    b_if.en = 0; b_if.dir = 0; b_if.skip_en = 0; b_if.clr = 0; b_if.load = 0; b_if.load_val = 0;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_if.count !== 4'd0) begin n_bad++; $display("FAIL reset_count_a: got %0d want 0", a_if.count); end
    n_cmp++; if (a_if.residue !== 2'd0) begin n_bad++; $display("FAIL reset_res_a: got %0d want 0", a_if.residue); end
    n_cmp++; if (a_if.wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap_a: got %b want 0", a_if.wrap); end
    n_cmp++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_a: got %b want 0", a_if.busy); end
    n_cmp++; if (b_if.count !== 4'd0) begin n_bad++; $display("FAIL reset_count_b: got %0d want 0", b_if.count); end
    n_cmp++; if (b_if.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy_b: got %b want 0", b_if.busy); end
    rst = 1;
    @(negedge clk);
    n_cmp++; if (a_if.count !== 4'd0) begin n_bad++; $display("FAIL hold_count_a: got %0d want 0", a_if.count); end
  endtask

  task automatic test_up_skip();
    int exp_c[11] = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14, 0};
    @(negedge clk);
    a_if.skip_en = 1; a_if.dir = 1; a_if.en = 1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      n_cmp++; if (a_if.count !== 4'(exp_c[i])) begin n_bad++; $display("FAIL up_count[%0d]: got %0d want %0d", i, a_if.count, exp_c[i]); end
      n_cmp++; if (a_if.residue !== 2'(exp_c[i] % 3)) begin n_bad++; $display("FAIL up_res[%0d]: got %0d want %0d", i, a_if.residue, exp_c[i] % 3); end
      n_cmp++; if (a_if.wrap !== (i == 10)) begin n_bad++; $display("FAIL up_wrap[%0d]: got %b want %b", i, a_if.wrap, (i == 10)); end
    end
    idle_a();
  endtask

  task automatic test_down_skip();
    int exp_c[12] = '{14, 13, 11, 10, 8, 7, 5, 4, 2, 1, 0, 14};
    @(negedge clk);
    a_if.skip_en = 1; a_if.dir = 0; a_if.en = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++; if (a_if.count !== 4'(exp_c[i])) begin n_bad++; $display("FAIL dn_count[%0d]: got %0d want %0d", i, a_if.count, exp_c[i]); end
      n_cmp++; if (a_if.residue !== 2'(exp_c[i] % 3)) begin n_bad++; $display("FAIL dn_res[%0d]: got %0d want %0d", i, a_if.residue, exp_c[i] % 3); end
      n_cmp++; if (a_if.wrap !== (i == 0 || i == 11)) begin n_bad++; $display("FAIL dn_wrap[%0d]: got %b want %b", i, a_if.wrap, (i == 0 || i == 11)); end
    end
    idle_a();
  endtask

  task automatic test_plain_up();
    @(negedge clk);
    a_if.skip_en = 0; a_if.dir = 1; a_if.en = 1; a_if.clr = 1;
    @(negedge clk);
    n_cmp++; if (a_if.count !== 4'd0) begin n_bad++; $display("FAIL clr_count: got %0d want 0", a_if.count); end
    n_cmp++; if (a_if.wrap !== 1'b0) begin n_bad++; $display("FAIL clr_wrap: got %b want 0", a_if.wrap); end
    a_if.clr = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++; if (a_if.count !== 4'((i + 1) % 16)) begin n_bad++; $display("FAIL plain_count[%0d]: got %0d want %0d", i, a_if.count, (i + 1) % 16); end
      n_cmp++; if (a_if.residue !== 2'(((i + 1) % 16) % 3)) begin n_bad++; $display("FAIL plain_res[%0d]: got %0d want %0d", i, a_if.residue, ((i + 1) % 16) % 3); end
      n_cmp++; if (a_if.wrap !== (i == 15)) begin n_bad++; $display("FAIL plain_wrap[%0d]: got %b want %b", i, a_if.wrap, (i == 15)); end
    end
    idle_a();
  endtask

  task automatic test_load();
    @(negedge clk);
    a_if.skip_en = 1; a_if.dir = 1; a_if.load = 1; a_if.load_val = 4'd9;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (a_if.busy !== 1'b1) begin n_bad++; $display("FAIL load_busy[%0d]: got %b want 1", i, a_if.busy); end
      n_cmp++; if (a_if.count !== 4'd9) begin n_bad++; $display("FAIL load_count[%0d]: got %0d want 9", i, a_if.count); end
      if (i == 0) begin a_if.en = 1; a_if.load_val = 4'd2; end
      if (i == 3) begin a_if.en = 0; a_if.load = 0; end
    end
    @(negedge clk);
    n_cmp++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL load_done_busy: got %b want 0", a_if.busy); end
    n_cmp++; if (a_if.count !== 4'd10) begin n_bad++; $display("FAIL load_done_count: got %0d want 10", a_if.count); end
    n_cmp++; if (a_if.residue !== 2'd1) begin n_bad++; $display("FAIL load_done_res: got %0d want 1", a_if.residue); end
    idle_a();
  endtask

  task automatic test_load_clamp();
    @(negedge clk);
    b_if.skip_en = 1; b_if.dir = 1; b_if.load = 1; b_if.load_val = 4'd14;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (b_if.busy !== 1'b1) begin n_bad++; $display("FAIL clamp_busy[%0d]: got %b want 1", i, b_if.busy); end
      n_cmp++; if (b_if.count !== 4'd11) begin n_bad++; $display("FAIL clamp_count[%0d]: got %0d want 11", i, b_if.count); end
      if (i == 0) b_if.load = 0;
    end
    @(negedge clk);
    n_cmp++; if (b_if.busy !== 1'b0) begin n_bad++; $display("FAIL clamp_done_busy: got %b want 0", b_if.busy); end
    n_cmp++; if (b_if.count !== 4'd11) begin n_bad++; $display("FAIL clamp_done_count: got %0d want 11", b_if.count); end
    n_cmp++; if (b_if.residue !== 2'd2) begin n_bad++; $display("FAIL clamp_done_res: got %0d want 2", b_if.residue); end
    b_if.en = 1;
    @(negedge clk);
    n_cmp++; if (b_if.count !== 4'd0) begin n_bad++; $display("FAIL clamp_wrap_count: got %0d want 0", b_if.count); end
    n_cmp++; if (b_if.wrap !== 1'b1) begin n_bad++; $display("FAIL clamp_wrap_pulse: got %b want 1", b_if.wrap); end
    n_cmp++; if (b_if.residue !== 2'd0) begin n_bad++; $display("FAIL clamp_wrap_res: got %0d want 0", b_if.residue); end
    b_if.en = 0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_if.skip_en = 1; a_if.load = 1; a_if.load_val = 4'd9;
    @(negedge clk);
    n_cmp++; if (a_if.busy !== 1'b1) begin n_bad++; $display("FAIL ar_busy_before: got %b want 1", a_if.busy); end
    a_if.load = 0;
    @(negedge clk);
    #2 rst = 0;
    #1;
    n_cmp++; if (a_if.count !== 4'd0) begin n_bad++; $display("FAIL ar_count: got %0d want 0", a_if.count); end
    n_cmp++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy: got %b want 0", a_if.busy); end
    n_cmp++; if (a_if.residue !== 2'd0) begin n_bad++; $display("FAIL ar_res: got %0d want 0", a_if.residue); end
    #1 rst = 1;
    a_if.clr = 1; a_if.load = 1; a_if.load_val = 4'd5; a_if.en = 1; a_if.dir = 1;
    @(negedge clk);
    n_cmp++; if (a_if.count !== 4'd0) begin n_bad++; $display("FAIL ar_clr_count: got %0d want 0", a_if.count); end
    n_cmp++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL ar_clr_busy: got %b want 0", a_if.busy); end
    n_cmp++; if (a_if.wrap !== 1'b0) begin n_bad++; $display("FAIL ar_clr_wrap: got %b want 0", a_if.wrap); end
    idle_a();
    @(negedge clk);
    n_cmp++; if (a_if.count !== 4'd0) begin n_bad++; $display("FAIL ar_idle_count: got %0d want 0", a_if.count); end
  endtask

  initial begin
    test_reset();
    test_up_skip();
    test_down_skip();
    test_plain_up();
    test_load();
    test_load_clamp();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
